// File: rtl/riscv_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_mem_arbiter_pkg                                                     |
// | Shared encodings for the fetch/data memory arbiter.                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package riscv_mem_arbiter_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_ERR   = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef logic [1:0] arb_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_lane_align                                                          |
// | Byte-lane enables, store replication, alignment check and load extract.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module riscv_lane_align
  import riscv_mem_arbiter_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  width,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_shift,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic [31:0] rd_data
);

  // Loads are shifted down to the LSBs only; upper bits are not masked or extended.
  function automatic logic [31:0] read_extract(input logic [31:0] word,
                                               input logic [1:0]  shift);
    return word >> {shift, 3'b000};
  endfunction

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = 32'h0000_0000;
    misaligned = 1'b1;
    case (width)
      WIDTH_BYTE: begin
        be         = 4'b0001 << addr;
        wdata_rep  = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      WIDTH_HALF: begin
        be         = 4'b0011 << addr;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      WIDTH_WORD: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = (addr != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  assign rd_data = read_extract(rdata, rd_shift);

endmodule

`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_mem_arbiter                                                         |
// | Shares one memory port between instruction fetch and load/store traffic.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
)
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] c_starve_max = STARVE_MAX[3:0];

  arb_state_t  r_state;
  logic        r_owner;
  logic [1:0]  r_rd_shift;
  logic [3:0]  r_starve_cnt;

  logic        w_starved;
  logic        w_pick_i;
  logic        w_pick_d;
  logic        w_in_issue;
  logic        w_in_wait;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic        w_misaligned;
  logic [31:0] w_rd_data;
  logic        w_unused_addr_lsb;

  // Fetch addresses are word aligned by contract, so their low bits carry nothing.
  assign w_unused_addr_lsb = &{1'b0, i_addr[1:0]};

  riscv_lane_align u_lane_align (
    .addr       (d_addr[1:0]),
    .width      (d_width),
    .wdata      (d_wdata),
    .rd_shift   (r_rd_shift),
    .rdata      (m_rdata),
    .be         (w_be),
    .wdata_rep  (w_wdata_rep),
    .misaligned (w_misaligned),
    .rd_data    (w_rd_data)
  );

  assign w_starved = (r_starve_cnt == c_starve_max);
  assign w_pick_i  = i_req && (!d_req || w_starved);
  assign w_pick_d  = d_req && !w_pick_i;

  assign w_in_issue = (r_state == ARB_ISSUE);
  assign w_in_wait  = (r_state == ARB_WAIT);

  assign i_gnt    = w_in_issue && m_ready  && (r_owner == OWN_I);
  assign d_gnt    = w_in_issue && m_ready  && (r_owner == OWN_D);
  assign i_rvalid = w_in_wait  && m_rvalid && (r_owner == OWN_I);
  assign d_rvalid = w_in_wait  && m_rvalid && (r_owner == OWN_D);
  assign d_err    = (r_state == ARB_ERR);

  assign i_rdata = i_rvalid ? m_rdata   : 32'h0000_0000;
  assign d_rdata = d_rvalid ? w_rd_data : 32'h0000_0000;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_I;
      r_rd_shift <= 2'b00;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= 32'h0000_0000;
      m_be       <= 4'b0000;
      m_wdata    <= 32'h0000_0000;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_i) begin
            r_owner    <= OWN_I;
            r_rd_shift <= 2'b00;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= word_align(i_addr);
            m_be       <= 4'b1111;
            m_wdata    <= 32'h0000_0000;
            r_state    <= ARB_ISSUE;
          end else if (w_pick_d) begin
            if (w_misaligned) begin
              r_state <= ARB_ERR;
            end else begin
              r_owner    <= OWN_D;
              r_rd_shift <= d_addr[1:0];
              m_req      <= 1'b1;
              m_we       <= d_we;
              m_addr     <= word_align(d_addr);
              m_be       <= w_be;
              m_wdata    <= w_wdata_rep;
              r_state    <= ARB_ISSUE;
            end
          end
        end
        ARB_ISSUE: begin
          if (m_ready) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            r_state <= m_we ? ARB_IDLE : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (m_rvalid) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_ERR: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Counts data wins over a waiting fetch; a fetch grant resets the window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (i_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (d_gnt && i_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_mem_arbiter                                                      |
// | Scoreboard bench with a byte-level reference memory and random traffic.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_riscv_mem_arbiter;

  localparam int STARVE = 4;
  localparam logic [1:0] K_ST = 2'd0, K_LD = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } dexp_t;

  logic        clock, reset_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_width;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] mem_w   [0:255];
  logic [31:0] i_exp_q [$];
  dexp_t       d_exp_q [$];
  bit          gnt_log [$];
  bit          d_ld_wait = 1'b0;
  bit          ready_rand = 1'b0;
  int          lat_lo = 1, lat_hi = 1;

  riscv_mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = {22'd0, addr[9:2], 2'b00};
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    mem_w[addr[9:2]] = val;
    for (int b = 0; b < 4; b++) ref_mem[{addr[9:2], 2'b00} + b] = val[8*b +: 8];
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {20'd0, m_req, m_we, m_be, i_gnt, d_gnt, i_rvalid, d_rvalid, d_err}, 32'd0);
    chk({name, "_maddr"}, m_addr, 32'd0);
    chk({name, "_mwdata"}, m_wdata, 32'd0);
    chk({name, "_rdata"}, i_rdata | d_rdata, 32'd0);
  endtask

  // Reference: expected data-port response from the access rules on a byte memory.
  task automatic exp_data(input logic we, input logic [31:0] addr,
                          input logic [1:0] width, input logic [31:0] wdata);
    dexp_t e;
    int    off, nb;
    bit    bad;
    off = addr[1:0];
    bad = (width == 2'd3) || (width == 2'd1 && (off % 2) != 0) || (width == 2'd2 && off != 0);
    e.data = 32'd0;
    if (bad) e.kind = K_ERR;
    else if (we) begin
      e.kind = K_ST;
      nb = 1 << width;
      for (int b = 0; b < nb; b++) ref_mem[addr[9:0] + b] = wdata[8*b +: 8];
    end else begin
      e.kind = K_LD;
      e.data = ref_word(addr) >> (8 * off);
    end
    d_exp_q.push_back(e);
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    int n;
    i_exp_q.push_back(ref_word(addr));
    i_req = 1'b1; i_addr = addr;
    n = 0;
    do begin @(negedge clock); n++; end while (!i_gnt && n < 200);
    if (!i_gnt) chk("i_gnt_timeout", 32'(i_gnt), 32'd1);
    @(posedge clock); #1;
    i_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr,
                         input logic [1:0] width, input logic [31:0] wdata);
    int n;
    exp_data(we, addr, width, wdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_width = width; d_wdata = wdata;
    n = 0;
    do begin @(negedge clock); n++; end while (!(d_gnt || d_err) && n < 200);
    if (!(d_gnt || d_err)) chk("d_gnt_timeout", 32'(d_gnt | d_err), 32'd1);
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  // Memory responder: in-order, one read outstanding, configurable latency.
  initial begin
    logic        acc, cwe;
    logic [31:0] caddr, cwd, rd_word;
    logic [3:0]  cbe;
    int          rd_wait, lat;
    rd_wait = 0; rd_word = 0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
    forever begin
      @(negedge clock);
      acc = m_req && m_ready; cwe = m_we; caddr = m_addr; cbe = m_be; cwd = m_wdata;
      @(posedge clock); #1;
      m_rvalid = 1'b0;
      m_rdata  = $urandom();
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin m_rvalid = 1'b1; m_rdata = rd_word; end
      end
      if (acc) begin
        if (cwe) begin
          for (int b = 0; b < 4; b++)
            if (cbe[b]) mem_w[caddr[9:2]][8*b +: 8] = cwd[8*b +: 8];
        end else begin
          rd_word = mem_w[caddr[9:2]];
          lat = $urandom_range(lat_hi, lat_lo);
          if (lat <= 1) begin m_rvalid = 1'b1; m_rdata = rd_word; end
          else rd_wait = lat - 1;
        end
      end
      m_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    dexp_t e;
    logic [31:0] exp;
    forever begin
      @(negedge clock);
      if (!reset_n) continue;
      if (i_gnt) gnt_log.push_back(1'b0);
      if (d_gnt) gnt_log.push_back(1'b1);
      if (i_gnt && d_gnt) chk("dual_gnt", 32'd1, 32'd0);
      if (i_rvalid) begin
        if (i_exp_q.size() == 0) chk("i_rvalid_unexpected", 32'd1, 32'd0);
        else begin exp = i_exp_q.pop_front(); chk("i_rdata", i_rdata, exp); end
      end else if (i_rdata != 32'd0) chk("i_rdata_idle", i_rdata, 32'd0);
      if (d_gnt) begin
        if (d_exp_q.size() == 0) chk("d_gnt_unexpected", 32'd1, 32'd0);
        else begin
          e = d_exp_q[0];
          chk("d_gnt_kind", 32'(m_we ? K_ST : K_LD), 32'(e.kind));
          if (e.kind == K_ST) void'(d_exp_q.pop_front());
          else if (e.kind == K_LD) d_ld_wait = 1'b1;
          else void'(d_exp_q.pop_front());
        end
      end
      if (d_rvalid) begin
        if (!d_ld_wait || d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
        else begin e = d_exp_q.pop_front(); d_ld_wait = 1'b0; chk("d_rdata", d_rdata, e.data); end
      end else if (d_rdata != 32'd0) chk("d_rdata_idle", d_rdata, 32'd0);
      if (d_err) begin
        if (d_exp_q.size() == 0) chk("d_err_unexpected", 32'd1, 32'd0);
        else begin e = d_exp_q.pop_front(); chk("d_err_kind", 32'(K_ERR), 32'(e.kind)); end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, streak;
    bit exp_b;
    reset_n = 1'b0; i_req = 1'b0; i_addr = 0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 0; d_width = 0; d_wdata = 0;
    for (int w = 0; w < 256; w++) set_word(32'(w * 4), $urandom());
    set_word(32'h100, 32'h0050_0093);
    set_word(32'h204, 32'hBEEF_1234);
    repeat (2) @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1; reset_n = 1'b1;
    repeat (2) begin @(posedge clock); #1; end

    // Single fetch: gnt at t+1, rvalid at t+2, idle at t+3
    i_exp_q.push_back(ref_word(32'h100));
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clock); chk("fetch_t0", {30'd0, m_req, i_gnt}, 32'd0);
    @(negedge clock); chk("fetch_t1", {29'd0, m_req, i_gnt, m_we}, 32'b110);
    chk("fetch_maddr", m_addr, 32'h100); chk("fetch_mbe", 32'(m_be), 32'hF);
    @(posedge clock); #1; i_req = 1'b0;
    @(negedge clock); chk("fetch_t2_rvalid", 32'(i_rvalid), 32'd1);
    chk("fetch_t2_rdata", i_rdata, 32'h0050_0093);
    @(negedge clock); chk("fetch_t3_rvalid", 32'(i_rvalid), 32'd0);
    @(posedge clock); #1;

    // Store byte 0xAB at 0x203
    exp_data(1'b1, 32'h203, 2'd0, 32'h0000_00AB);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h203; d_width = 2'd0; d_wdata = 32'h0000_00AB;
    @(negedge clock); chk("sb_t0_gnt", 32'(d_gnt), 32'd0);
    @(negedge clock); chk("sb_gnt", {30'd0, d_gnt, m_we}, 32'b11);
    chk("sb_mbe", 32'(m_be), 32'b1000); chk("sb_mwdata", m_wdata, 32'hABAB_ABAB);
    chk("sb_maddr", m_addr, 32'h200);
    @(posedge clock); #1; d_req = 1'b0;
    @(negedge clock); chk("sb_gnt_pulse", {30'd0, d_gnt, m_req}, 32'd0);
    @(posedge clock); #1;

    // Load half at 0x206 from 0xBEEF1234
    exp_data(1'b0, 32'h206, 2'd1, 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h206; d_width = 2'd1;
    @(negedge clock); @(negedge clock); chk("lh_gnt", 32'(d_gnt), 32'd1);
    @(posedge clock); #1; d_req = 1'b0;
    @(negedge clock); chk("lh_rvalid", 32'(d_rvalid), 32'd1);
    chk("lh_rdata", d_rdata, 32'h0000_BEEF);
    @(posedge clock); #1;

    // Misaligned load word at 0x301
    exp_data(1'b0, 32'h301, 2'd2, 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h301; d_width = 2'd2;
    @(negedge clock); chk("err_t0", 32'(d_err), 32'd0);
    @(negedge clock); chk("err_t1", {29'd0, d_err, m_req, d_gnt}, 32'b100);
    @(posedge clock); #1; d_req = 1'b0;
    @(negedge clock); chk("err_t2", {29'd0, d_err, m_req, d_gnt}, 32'd0);
    @(posedge clock); #1;

    // Both requesting continuously: fetch every STARVE+1 grants
    gnt_log.delete();
    fork
      begin repeat (3) do_fetch(32'($urandom_range(0, 63) * 4)); end
      begin for (int k = 0; k < 14; k++) do_data(1'b0, 32'h100 + 32'(k * 4), 2'd2, 32'd0); end
    join
    chk("starve_log_len", 32'(gnt_log.size() >= 15), 32'd1);
    streak = 0;
    for (int k = 0; k < 15 && k < gnt_log.size(); k++) begin
      exp_b = (streak != STARVE);
      streak = exp_b ? streak + 1 : 0;
      chk($sformatf("starve_order_%0d", k), 32'(gnt_log[k]), 32'(exp_b));
    end

    // Reset while a fetch read is outstanding; its late m_rvalid must be ignored
    lat_lo = 3; lat_hi = 3;
    i_exp_q.push_back(ref_word(32'h040));
    i_req = 1'b1; i_addr = 32'h040;
    n = 0;
    do begin @(negedge clock); n++; end while (!i_gnt && n < 50);
    chk("rst_pre_gnt", 32'(i_gnt), 32'd1);
    @(posedge clock); #1; i_req = 1'b0; reset_n = 1'b0; i_exp_q.delete();
    @(negedge clock); check_zero("rst_mid");
    @(posedge clock); #1; reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("rst_stray_%0d", k), {30'd0, i_rvalid, d_rvalid}, 32'd0);
    end
    lat_lo = 1; lat_hi = 1;
    @(posedge clock); #1;
    do_fetch(32'h080);

    // Randomized mixed traffic with memory back-pressure and variable latency
    ready_rand = 1'b1; lat_lo = 1; lat_hi = 3;
    fork
      begin
        repeat (30) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          do_fetch(32'($urandom_range(0, 63) * 4));
        end
      end
      begin
        repeat (60) begin
          logic [1:0] wd;
          wd = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          do_data(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 767)), wd, $urandom());
        end
      end
    join

    n = 0;
    while ((i_exp_q.size() != 0 || d_exp_q.size() != 0) && n < 300) begin
      @(negedge clock); n++;
    end
    chk("drain", 32'(i_exp_q.size() + d_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
